// File: rtl/risc24_mem_responder.sv
// Purpose: data-memory stand-in for the RISC-24 core; one word request at a time, held for LATENCY wait states, then committed to an internal array and answered.
// Latency: accepted at edge N, committed at edge N+LATENCY, resp_valid from the following cycle; back-to-back period is LATENCY+2 cycles.
// Backpressure: req_ready is low from acceptance until the response is consumed; the response is held stable while resp_ready is low.
// Optional feature: define RISC24_MEM_RANGE_CHECK_EN to flag addresses outside the array (resp_err=1, write suppressed, read data 0).
module risc24_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [15:0] o_resp_rdata,
    output logic        o_resp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1 so that the commit edge is the LATENCY-th edge after acceptance.
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [15:0] r_rdata;
    logic        r_err;

    // Word array; contents deliberately survive reset.
    logic [15:0] r_mem [2**DEPTH_LOG2];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_c_write;
    logic [15:0]           w_c_addr;
    logic [15:0]           w_c_wdata;
    logic [DEPTH_LOG2-1:0] w_c_idx;
    logic                  w_c_oor;
    logic                  w_mem_we;
    logic [15:0]           w_rdata_next;

    assign w_accept = (r_state == S_IDLE) && i_req_valid;

    // With zero wait states the commit happens on the acceptance edge, so the live request fields are used.
    assign w_commit  = (w_accept && (LATENCY == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_c_write = (r_state == S_IDLE) ? i_req_write : r_write;
    assign w_c_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    assign w_c_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
    assign w_c_idx   = w_c_addr[DEPTH_LOG2-1:0];

`ifdef RISC24_MEM_RANGE_CHECK_EN
    assign w_c_oor = |w_c_addr[15:DEPTH_LOG2];
`else
    // Upper address bits alias onto the array.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^w_c_addr[15:DEPTH_LOG2];
    assign w_c_oor          = 1'b0;
`endif

    // Reset gating keeps a zero-latency write from landing while reset is held.
    assign w_mem_we     = w_commit && w_c_write && !w_c_oor && !i_reset;
    assign w_rdata_next = (w_c_write || w_c_oor) ? 16'h0000 : r_mem[w_c_idx];

    // Array write port: commits the access on the commit edge.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= 16'h0000;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write     <= i_req_write;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_rdata      <= w_rdata_next;
                            r_err        <= w_c_oor;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata      <= w_rdata_next;
                        r_err        <= w_c_oor;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

endmodule

// File: tb/tb_risc24_mem_responder.sv
// Testbench for risc24_mem_responder: two instances (LATENCY=2 and LATENCY=0) driven with
// directed and random traffic; a scoreboard queue per instance is checked by an independent monitor.
module tb_risc24_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          first_cyc;
    } exp_t;

    task automatic chk(input int lat, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [LAT=%0d] %s: got 0x%0h, expected 0x%0h", lat, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : 0;

        logic        rst        = 1'b1;
        logic        req_valid  = 1'b0;
        logic        req_write  = 1'b0;
        logic [15:0] req_addr   = 16'h0;
        logic [15:0] req_wdata  = 16'h0;
        logic        resp_ready = 1'b1;
        logic        req_ready;
        logic        resp_valid;
        logic [15:0] resp_rdata;
        logic        resp_err;

        risc24_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
            .i_clk        (clk),
            .i_reset      (rst),
            .i_req_valid  (req_valid),
            .i_req_write  (req_write),
            .i_req_addr   (req_addr),
            .i_req_wdata  (req_wdata),
            .o_req_ready  (req_ready),
            .o_resp_valid (resp_valid),
            .i_resp_ready (resp_ready),
            .o_resp_rdata (resp_rdata),
            .o_resp_err   (resp_err)
        );

        // Reference model: a plain word array plus the queue of expected responses.
        logic [15:0] model_mem [256];
        exp_t        q[$];
        bit          held    = 0;
        int          hold_cnt = 0;
        bit          rand_rr = 0;
        int          last_hs = 0;

        // Monitor: drives resp_ready and checks every cycle a response is presented.
        initial begin
            forever begin
                @(negedge clk);
                if (rst) begin
                    held = 0;
                end else begin
                    if (hold_cnt > 0) begin
                        resp_ready = 1'b0;
                        if (resp_valid) hold_cnt--;
                    end else if (rand_rr) begin
                        resp_ready = ($urandom_range(2) != 0);
                    end else begin
                        resp_ready = 1'b1;
                    end
                    if (resp_valid) begin
                        if (q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL [LAT=%0d] unexpected_resp: got resp_valid=1, expected no response", LAT);
                        end else begin
                            if (!held) begin
                                chk(LAT, "resp_first_cycle", cyc, q[0].first_cyc);
                                held = 1;
                            end
                            chk(LAT, "resp_rdata", resp_rdata, q[0].rdata);
                            chk(LAT, "resp_err", resp_err, q[0].err);
                            if (resp_ready) begin
                                void'(q.pop_front());
                                held    = 0;
                                last_hs = cyc + 1;
                            end
                        end
                    end
                end
            end
        end

        // Present one request, wait for acceptance, record the expected response.
        task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d, output int acc);
            int   guard;
            exp_t e;
            bit   oor;
            guard = 0;
            @(negedge clk);
            req_valid = 1'b1;
            req_write = wr;
            req_addr  = a;
            req_wdata = d;
            while (!req_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (!req_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL [LAT=%0d] accept_timeout: got req_ready=0 for 500 cycles, expected acceptance", LAT);
                req_valid = 1'b0;
                acc = -1;
                return;
            end
            acc = cyc + 1;
`ifdef RISC24_MEM_RANGE_CHECK_EN
            oor = (a[15:8] != 8'h00);
`else
            oor = 1'b0;
`endif
            e.err       = oor;
            e.first_cyc = acc + LAT;
            if (wr) begin
                e.rdata = 16'h0000;
                if (!oor) model_mem[a[7:0]] = d;
            end else begin
                e.rdata = oor ? 16'h0000 : model_mem[a[7:0]];
            end
            q.push_back(e);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        endtask

        // Wait until every outstanding response has been consumed.
        task automatic drain();
            int guard;
            guard = 0;
            while ((q.size() != 0 || resp_valid) && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL [LAT=%0d] drain_timeout: got %0d responses pending, expected 0", LAT, q.size());
                q.delete();
            end
            @(negedge clk);
        endtask

        task automatic chk_reset_outputs(input string tag);
            chk(LAT, {tag, "_req_ready"},  req_ready,  1);
            chk(LAT, {tag, "_resp_valid"}, resp_valid, 0);
            chk(LAT, {tag, "_resp_rdata"}, resp_rdata, 0);
            chk(LAT, {tag, "_resp_err"},   resp_err,   0);
        endtask

        initial begin
            int acc, acc2, lowc;
            bit committed, wr;
            logic [15:0] a;

            repeat (2) @(negedge clk);
            chk_reset_outputs("por");
            rst = 1'b0;

            // Give every word a known value.
            for (int i = 0; i < 256; i++) issue(1'b1, 16'(i), 16'($urandom), acc);
            drain();

            // Write then read back; req_ready must drop for LAT+1 cycles.
            issue(1'b1, 16'h0010, 16'hBEEF, acc);
            lowc = 0;
            @(negedge clk);
            while (!req_ready && lowc < 100) begin
                lowc++;
                @(negedge clk);
            end
            chk(LAT, "req_ready_low_cycles", lowc, LAT + 1);
            issue(1'b0, 16'h0010, 16'h0000, acc);
            drain();

            // Stall the response for 5 cycles while a second request waits.
            hold_cnt = 5;
            issue(1'b0, 16'h0010, 16'h0000, acc);
            issue(1'b0, 16'h0011, 16'h0000, acc2);
            chk(LAT, "accept_after_release", acc2, last_hs + 1);
            drain();

            // Out-of-range write and read-back of its aliased word.
            issue(1'b1, 16'h0120, 16'h0F0F, acc);
            issue(1'b0, 16'h0020, 16'h0000, acc);
            drain();

            // Reset one edge after accepting a write that follows a known value.
            issue(1'b1, 16'h0020, 16'h5555, acc);
            drain();
            hold_cnt = 1000;
            issue(1'b1, 16'h0020, 16'hAAAA, acc);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk_reset_outputs("midreset");
            committed = (LAT <= 1);
            if (!committed) model_mem[8'h20] = 16'h5555;
            q.delete();
            hold_cnt = 0;
            @(negedge clk);
            rst = 1'b0;
            issue(1'b0, 16'h0020, 16'h0000, acc);
            drain();

            // Random traffic with random response backpressure.
            rand_rr = 1;
            for (int i = 0; i < 300; i++) begin
                wr = 1'($urandom);
                a  = ($urandom_range(3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
                issue(wr, a, 16'($urandom), acc);
                repeat ($urandom_range(2)) @(negedge clk);
            end
            drain();
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 90000 && done_cnt < 2; i++) @(negedge clk);
        if (done_cnt < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL global_timeout: got %0d instances finished, expected 2", done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
